// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one word per frame.
// Hits return data in the same cycle; misses fetch one word over an iREN/iwait handshake.
module icache_direct #(
  parameter int IDX_W  = 4,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int FRAMES = 2 ** IDX_W;
  localparam int TAG_W  = WORD_W - IDX_W - 2;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state;
  logic [FRAMES-1:0] valid;
  logic [TAG_W-1:0]  tags [FRAMES];
  logic [WORD_W-1:0] data [FRAMES];
  logic [WORD_W-1:0] miss_addr;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  miss_tag;
  logic              lookup_hit;
  logic              fill;

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[WORD_W-1:IDX_W+2];
  assign miss_idx = miss_addr[IDX_W+1:2];
  assign miss_tag = miss_addr[WORD_W-1:IDX_W+2];

  assign lookup_hit = imemREN && valid[req_idx] && (tags[req_idx] == req_tag);
  assign fill       = (state == FETCH) && !iwait;

  // Hit data is combinational so the fetch stage sees it in the request cycle.
  assign ihit     = (state == IDLE) && lookup_hit;
  assign imemload = ihit ? data[req_idx] : '0;
  assign iaddr    = iREN ? miss_addr : '0;

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      valid      <= '0;
      iREN       <= 1'b0;
      miss_addr  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lookup_hit) begin
            hit_count <= hit_count + 32'd1;
          end else if (imemREN) begin
            miss_addr  <= imemaddr & ~WORD_W'(3);
            miss_count <= miss_count + 32'd1;
            iREN       <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          // The fill targets the latched miss address, not the live request.
          if (!iwait) begin
            valid[miss_idx] <= 1'b1;
            iREN            <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits alone
  // make stale contents unobservable, and unreset arrays map onto plain flops/RAM.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[miss_idx] <= miss_tag;
      data[miss_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: a per-frame address/data model checked every
// cycle, plus hand-computed expectations for the main scenarios.
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'hDEAD_BEEF;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  icache_direct #(.IDX_W(4), .WORD_W(32)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference cache: each frame remembers the word address it holds and its data.
  bit          ref_valid [16];
  logic [31:0] ref_addr  [16];
  logic [31:0] ref_data  [16];
  bit          pending;
  logic [31:0] pend_addr;
  logic [31:0] exp_hits;
  logic [31:0] exp_misses;

  always @(negedge CLK) begin
    logic [31:0] waddr;
    int          idx;
    bit          hit;
    if (!nRST) begin
      for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
      pending    = 1'b0;
      pend_addr  = '0;
      exp_hits   = '0;
      exp_misses = '0;
      check("rst_ihit", {31'd0, ihit}, 32'd0);
      check("rst_iren", {31'd0, iREN}, 32'd0);
      check("rst_iaddr", iaddr, 32'd0);
      check("rst_imemload", imemload, 32'd0);
      check("rst_hit_count", hit_count, 32'd0);
      check("rst_miss_count", miss_count, 32'd0);
    end else begin
      waddr = imemaddr & 32'hFFFF_FFFC;
      idx   = int'((imemaddr >> 2) % 32'd16);
      hit   = !pending && imemREN && ref_valid[idx] && (ref_addr[idx] == waddr);
      check("cyc_ihit", {31'd0, ihit}, {31'd0, hit});
      check("cyc_imemload", imemload, hit ? ref_data[idx] : 32'd0);
      check("cyc_iren", {31'd0, iREN}, {31'd0, pending});
      check("cyc_iaddr", iaddr, pending ? pend_addr : 32'd0);
      check("cyc_hit_count", hit_count, exp_hits);
      check("cyc_miss_count", miss_count, exp_misses);
      check("cyc_ihit_and_iren", {31'd0, ihit && iREN}, 32'd0);
      if (pending) begin
        if (!iwait) begin
          ref_valid[int'((pend_addr >> 2) % 32'd16)] = 1'b1;
          ref_addr[int'((pend_addr >> 2) % 32'd16)]  = pend_addr;
          ref_data[int'((pend_addr >> 2) % 32'd16)]  = iload;
          pending = 1'b0;
        end
      end else if (imemREN) begin
        if (hit) begin
          exp_hits = exp_hits + 32'd1;
        end else begin
          pending    = 1'b1;
          pend_addr  = waddr;
          exp_misses = exp_misses + 32'd1;
        end
      end
    end
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  // Entered at the start of the first FETCH cycle; returns at the start of the
  // first IDLE cycle after the fill edge.
  task automatic serve(input int waits, input logic [31:0] word);
    iwait = 1'b1;
    repeat (waits) cycle();
    iwait = 1'b0;
    iload = word;
    cycle();
    iwait = 1'b1;
    iload = 32'hDEAD_BEEF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_iren", {31'd0, iREN}, 32'd0);
    check("reset_iaddr", iaddr, 32'd0);

    // 1: cold miss on 0x0, three wait cycles
    nRST = 1'b1; imemREN = 1'b1; imemaddr = 32'h0;
    #1 check("t1_first_ihit", {31'd0, ihit}, 32'd0);
    cycle();
    check("t1_iren", {31'd0, iREN}, 32'd1);
    check("t1_iaddr", iaddr, 32'h0);
    serve(3, 32'h8C22_0004);
    check("t1_hit", {31'd0, ihit}, 32'd1);
    check("t1_imemload", imemload, 32'h8C22_0004);
    check("t1_miss_count", miss_count, 32'd1);

    // 2: byte offset ignored, five consecutive hits
    imemaddr = 32'h2;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t2_ihit", {31'd0, ihit}, 32'd1);
      check("t2_imemload", imemload, 32'h8C22_0004);
      check("t2_iren", {31'd0, iREN}, 32'd0);
      cycle();
    end
    check("t2_hit_count", hit_count, 32'd5);

    // 3: conflict on index 0
    imemaddr = 32'h40;
    #1 check("t3_miss", {31'd0, ihit}, 32'd0);
    cycle();
    serve(0, 32'h3C01_0001);
    check("t3_hit40", {31'd0, ihit}, 32'd1);
    check("t3_load40", imemload, 32'h3C01_0001);
    cycle();
    imemaddr = 32'h0;
    #1 check("t3_evicted", {31'd0, ihit}, 32'd0);
    cycle();
    check("t3_iren", {31'd0, iREN}, 32'd1);
    check("t3_miss_count", miss_count, 32'd3);
    serve(0, 32'h8C22_0004);

    // 4: request redirected while the fetch is outstanding
    imemaddr = 32'h10;
    cycle();
    check("t4_iaddr_a", iaddr, 32'h10);
    imemaddr = 32'h80;
    cycle();
    check("t4_iaddr_b", iaddr, 32'h10);
    cycle();
    check("t4_iaddr_c", iaddr, 32'h10);
    serve(0, 32'h2402_000A);
    #1 check("t4_miss80", {31'd0, ihit}, 32'd0);
    cycle();
    check("t4_iaddr80", iaddr, 32'h80);
    serve(1, 32'hAC03_0008);
    check("t4_hit80", {31'd0, ihit}, 32'd1);
    check("t4_load80", imemload, 32'hAC03_0008);
    imemaddr = 32'h10;
    #1;
    check("t4_hit10", {31'd0, ihit}, 32'd1);
    check("t4_load10", imemload, 32'h2402_000A);
    cycle();

    // 5: asynchronous reset in the middle of a fetch
    imemaddr = 32'h20;
    cycle();
    check("t5_iren_before", {31'd0, iREN}, 32'd1);
    nRST = 1'b0;
    #1;
    check("t5_iren_async", {31'd0, iREN}, 32'd0);
    check("t5_miss_count_async", miss_count, 32'd0);
    cycle();
    nRST = 1'b1;
    imemaddr = 32'h0;
    #1;
    check("t5_cold_after_reset", {31'd0, ihit}, 32'd0);
    check("t5_hit_count", hit_count, 32'd0);
    check("t5_miss_count", miss_count, 32'd0);
    cycle();
    check("t5_refetch_iren", {31'd0, iREN}, 32'd1);
    check("t5_refetch_count", miss_count, 32'd1);
    serve(0, 32'h8C22_0004);
    cycle();

    // 6: no request while a valid address is presented
    imemREN = 1'b0;
    imemaddr = 32'h0;
    #1;
    check("t6_ihit", {31'd0, ihit}, 32'd0);
    check("t6_imemload", imemload, 32'd0);
    check("t6_iren", {31'd0, iREN}, 32'd0);
    repeat (3) cycle();
    check("t6_hit_count", hit_count, 32'd1);
    check("t6_miss_count", miss_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
